// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MIPS datapath (fetch and load/store ports), the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the datapath/memory side.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [1:0]  d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;

    logic        mem_en;
    logic [1:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one 64-bit memory port between instruction fetch and load/store.
// Load/store has priority; a saturating starvation counter forces a pending fetch through.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(MEM_LAT + 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);

    logic [0:0]    state;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          owner_d;
    logic          i_hi;

    logic          can_grant;
    logic          force_i;
    logic          pick_d;
    logic          pick_i;
    logic          d_is_read;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + SW'(1);
    endfunction

    // Winner selection: reset suppresses any grant in the same cycle.
    always_comb begin
        can_grant = (state == IDLE) && !reset;
        force_i   = bus.i_req && (starve_cnt == STARVE_LIM);
        pick_d    = can_grant && bus.d_req && !force_i;
        pick_i    = can_grant && bus.i_req && !pick_d;
        d_is_read = (bus.d_we == 2'b00);
    end

    always_comb begin
        bus.i_gnt     = pick_i;
        bus.d_gnt     = pick_d;
        bus.mem_en    = pick_i || pick_d;
        bus.mem_we    = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (pick_d) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (pick_i) begin
            bus.mem_addr  = bus.i_addr;
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            starve_cnt   <= '0;
            owner_d      <= 1'b0;
            i_hi         <= 1'b0;
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;

            if (pick_d) begin
                starve_cnt <= bus.i_req ? sat_inc(starve_cnt) : '0;
            end else if (pick_i) begin
                starve_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    // Stores complete in the grant cycle; only reads occupy the port.
                    if (pick_i || (pick_d && d_is_read)) begin
                        state   <= WAIT;
                        lat_cnt <= LAT_INIT;
                        owner_d <= pick_d;
                        i_hi    <= bus.i_addr[2];
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                        if (owner_d) begin
                            bus.d_rdata  <= bus.mem_rdata;
                            bus.d_rvalid <= 1'b1;
                        end else begin
                            bus.i_rdata  <= i_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                            bus.i_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions plus hand sequences for
// priority/starvation, request-during-WAIT and reset-during-read, with a latency memory model.
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } vec_t;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    logic [63:0] i_q[$];
    logic [63:0] d_q[$];
    logic [63:0] mem [logic [60:0]];
    logic [63:0] hist [MEM_LAT];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory returns data MEM_LAT cycles after the access strobe.
    always @(negedge clk) begin : memory_model
        logic [63:0] rd;
        rd = 64'h0;
        bus.mem_rdata = hist[MEM_LAT-1];
        if (bus.mem_en) begin
            if (bus.mem_we != 2'b00) mem[bus.mem_addr[63:3]] = bus.mem_wdata;
            else if (mem.exists(bus.mem_addr[63:3])) rd = mem[bus.mem_addr[63:3]];
        end
        for (int k = MEM_LAT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = rd;
    end

    always @(negedge clk) begin : scoreboard
        if (bus.i_rvalid) begin
            if (i_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL i_rvalid_unexpected: got pulse, expected none");
            end else begin
                chk("i_rdata", {32'h0, bus.i_rdata}, i_q.pop_front());
            end
        end
        if (bus.d_rvalid) begin
            if (d_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d_rvalid_unexpected: got pulse, expected none");
            end else begin
                chk("d_rdata", bus.d_rdata, d_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        logic is_d;
        logic rv;
        is_d = (v.kind != K_FETCH);
        if (is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        @(negedge clk);
        chk($sformatf("v%0d_gnt", idx), is_d ? bus.d_gnt : bus.i_gnt, 1);
        chk($sformatf("v%0d_other_gnt", idx), is_d ? bus.i_gnt : bus.d_gnt, 0);
        chk($sformatf("v%0d_mem_en", idx), bus.mem_en, 1);
        chk($sformatf("v%0d_mem_we", idx), bus.mem_we, is_d ? v.we : 2'b00);
        chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
        chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, is_d ? v.wdata : 64'h0);
        if (v.kind == K_FETCH) i_q.push_back(v.rdata);
        else if (v.kind == K_LOAD) d_q.push_back(v.rdata);
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        if (v.kind == K_STORE) begin
            chk($sformatf("v%0d_store_busy", idx), bus.busy, 0);
            chk($sformatf("v%0d_store_rvalid", idx), bus.d_rvalid, 0);
        end else begin
            chk($sformatf("v%0d_wait_busy", idx), bus.busy, 1);
            chk($sformatf("v%0d_wait_mem_en", idx), bus.mem_en, 0);
            chk($sformatf("v%0d_wait_mem_addr", idx), bus.mem_addr, 64'h0);
            n  = 1;
            rv = is_d ? bus.d_rvalid : bus.i_rvalid;
            while (n < 20 && !rv) begin
                @(negedge clk);
                n++;
                rv = is_d ? bus.d_rvalid : bus.i_rvalid;
            end
            chk($sformatf("v%0d_rvalid_latency", idx), n, MEM_LAT + 1);
            @(negedge clk);
            chk($sformatf("v%0d_rvalid_pulse", idx), is_d ? bus.d_rvalid : bus.i_rvalid, 0);
            chk($sformatf("v%0d_rdata_hold", idx), is_d ? bus.d_rdata : {32'h0, bus.i_rdata}, v.rdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t        vecs[12];
        vec_t        fresh;
        logic [11:0] pat_d;
        logic [11:0] pat_i;
        int          n;

        vecs[0]  = '{K_FETCH, 2'b00, 64'h4,    64'h0,  64'h11223344};
        vecs[1]  = '{K_FETCH, 2'b00, 64'h0,    64'h0,  64'h55667788};
        vecs[2]  = '{K_STORE, 2'b10, 64'd100,  64'd7,  64'h0};
        vecs[3]  = '{K_LOAD,  2'b00, 64'd100,  64'h0,  64'd7};
        vecs[4]  = '{K_STORE, 2'b01, 64'h200,  64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[5]  = '{K_FETCH, 2'b00, 64'h204,  64'h0,  64'hDEADBEEF};
        vecs[6]  = '{K_FETCH, 2'b00, 64'h200,  64'h0,  64'hCAFEF00D};
        vecs[7]  = '{K_LOAD,  2'b00, 64'h200,  64'h0,  64'hDEADBEEF_CAFEF00D};
        vecs[8]  = '{K_LOAD,  2'b00, 64'h1000, 64'h55, 64'h0};
        vecs[9]  = '{K_STORE, 2'b11, 64'h8,    64'hFFFFFFFF_00000001, 64'h0};
        vecs[10] = '{K_LOAD,  2'b00, 64'h8,    64'h0,  64'hFFFFFFFF_00000001};
        vecs[11] = '{K_FETCH, 2'b00, 64'hC,    64'h0,  64'hFFFFFFFF};

        foreach (hist[k]) hist[k] = 64'h0;
        mem[61'd0] = 64'h1122334455667788;

        // Reset held two cycles with both requesters active.
        reset       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 64'h4;
        bus.d_req   = 1'b1;
        bus.d_we    = 2'b00;
        bus.d_addr  = 64'd100;
        bus.d_wdata = 64'h0;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_i_gnt", c), bus.i_gnt, 0);
            chk($sformatf("rst%0d_d_gnt", c), bus.d_gnt, 0);
            chk($sformatf("rst%0d_mem_en", c), bus.mem_en, 0);
            chk($sformatf("rst%0d_busy", c), bus.busy, 0);
            chk($sformatf("rst%0d_i_rvalid", c), bus.i_rvalid, 0);
            chk($sformatf("rst%0d_d_rvalid", c), bus.d_rvalid, 0);
            @(posedge clk); #1;
        end
        chk("rst_i_rdata", {32'h0, bus.i_rdata}, 64'h0);
        chk("rst_d_rdata", bus.d_rdata, 64'h0);
        reset     = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;

        for (int v = 0; v < 12; v++) run_vec(vecs[v], v);

        // Both requesting: four D stores, then a forced fetch; repeats once the counter clears.
        pat_d = 12'b0111_1000_1111;
        pat_i = 12'b1000_0001_0000;
        bus.d_req   = 1'b1;
        bus.d_we    = 2'b01;
        bus.d_addr  = 64'h300;
        bus.d_wdata = 64'hA5;
        bus.i_req   = 1'b1;
        bus.i_addr  = 64'h4;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("prio_c%0d_d_gnt", c), bus.d_gnt, pat_d[c]);
            chk($sformatf("prio_c%0d_i_gnt", c), bus.i_gnt, pat_i[c]);
            if (bus.i_gnt) i_q.push_back(64'h11223344);
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_rvalid && n < 20);
        chk("prio_last_fetch_latency", n, MEM_LAT + 1);
        @(posedge clk); #1;

        // Load request raised while a fetch is outstanding.
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h204;
        @(negedge clk);
        chk("wreq_i_gnt", bus.i_gnt, 1);
        i_q.push_back(64'hDEADBEEF);
        @(posedge clk); #1;
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 2'b00;
        bus.d_addr  = 64'h200;
        bus.d_wdata = 64'h0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("wreq_t%0d_d_gnt", c), bus.d_gnt, 0);
        end
        @(negedge clk);
        chk("wreq_t3_d_gnt", bus.d_gnt, 1);
        chk("wreq_t3_i_rvalid", bus.i_rvalid, 1);
        chk("wreq_t3_mem_addr", bus.mem_addr, 64'h200);
        d_q.push_back(64'hDEADBEEF_CAFEF00D);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_rvalid && n < 20);
        chk("wreq_load_latency", n, MEM_LAT + 1);
        @(posedge clk); #1;

        // Reset one cycle into a load: the read is dropped.
        bus.d_req  = 1'b1;
        bus.d_we   = 2'b00;
        bus.d_addr = 64'd100;
        @(negedge clk);
        chk("rwait_d_gnt", bus.d_gnt, 1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rwait_t1_busy", bus.busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rwait_t2_busy", bus.busy, 0);
        chk("rwait_t2_d_rvalid", bus.d_rvalid, 0);
        for (int c = 3; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rwait_t%0d_d_rvalid", c), bus.d_rvalid, 0);
        end
        @(posedge clk); #1;
        fresh = '{K_FETCH, 2'b00, 64'h0, 64'h0, 64'h55667788};
        run_vec(fresh, 12);

        repeat (3) @(posedge clk);
        #1;
        chk("i_queue_drained", i_q.size(), 0);
        chk("d_queue_drained", d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
